// File: rtl/jtcop_paldma_if.sv
// Bus bundle for the palette DMA sequencer: vblank/request inputs, the CPU
// palette write path, the buffer RAM read port, the palette RAM write port
// and status. The optional clr request line exists only when
// JTCOP_PALDMA_CLR_EN is defined.
// master: the DMA engine's view. slave: the surrounding system's view.
interface jtcop_paldma_if #(
    parameter int AW = 10,
    parameter int DW = 16
);
    logic          LVBL;
    logic          dma_req;
`ifdef JTCOP_PALDMA_CLR_EN
    logic          clr;
`endif
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_dout;
    logic [1:0]    cpu_we;
    logic          buf_cs;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_dout;
    logic          buf_ok;
    logic [AW-1:0] pal_addr;
    logic [DW-1:0] pal_dout;
    logic [1:0]    pal_we;
    logic          busy;
    logic          done;

    modport master (
`ifdef JTCOP_PALDMA_CLR_EN
        input  clr,
`endif
        input  LVBL, dma_req, cpu_addr, cpu_dout, cpu_we, buf_dout, buf_ok,
        output buf_cs, buf_addr, pal_addr, pal_dout, pal_we, busy, done
    );

    modport slave (
`ifdef JTCOP_PALDMA_CLR_EN
        output clr,
`endif
        output LVBL, dma_req, cpu_addr, cpu_dout, cpu_we, buf_dout, buf_ok,
        input  buf_cs, buf_addr, pal_addr, pal_dout, pal_we, busy, done
    );
endinterface

// File: rtl/jtcop_paldma.sv
// Palette DMA sequencer. A CPU request arms a copy of the whole palette
// (2^AW words) from the buffer RAM into the palette RAM, started at the next
// vblank start (LVBL falling edge). Direct CPU palette writes share the
// palette write port and always win; a DMA write blocked by the CPU is simply
// retried on the next cycle. Optional macro JTCOP_PALDMA_CLR_EN adds a clr
// request line that turns the transfer into a zero fill (no buffer reads).
module jtcop_paldma #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic           clk,
    input  logic           rst,
    jtcop_paldma_if.master bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_VB = 2'd1;
    localparam logic [1:0] ST_READ    = 2'd2;
    localparam logic [1:0] ST_WRITE   = 2'd3;
    localparam logic [AW-1:0] LAST_WORD = {AW{1'b1}};

    logic [1:0]    state_q, state_d;
    logic          pending_q, pending_d;
    logic          clr_pend_q, clr_pend_d;   // request kind waiting with pending
    logic          clr_mode_q, clr_mode_d;   // kind of the transfer in flight
    logic          lvbl_q;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] pal_addr_q, pal_addr_d;
    logic [DW-1:0] pal_dout_q, pal_dout_d;
    logic [1:0]    pal_we_q, pal_we_d;
    logic          done_q, done_d;
    logic          vb_start;
    logic          req_clr;

`ifdef JTCOP_PALDMA_CLR_EN
    assign req_clr = bus.clr;
`else
    assign req_clr = 1'b0;
`endif

    assign vb_start     = lvbl_q & ~bus.LVBL;
    assign bus.buf_cs   = (state_q == ST_READ);
    assign bus.buf_addr = cnt_q;
    assign bus.pal_addr = pal_addr_q;
    assign bus.pal_dout = pal_dout_q;
    assign bus.pal_we   = pal_we_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;

    // Next-state logic: transfer FSM, then CPU override of the write port,
    // then request capture (a request is never lost, whatever the state).
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        clr_pend_d = clr_pend_q;
        clr_mode_d = clr_mode_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        pal_addr_d = pal_addr_q;
        pal_dout_d = pal_dout_q;
        pal_we_d   = 2'b00;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pending_q) state_d = ST_WAIT_VB;
            end
            ST_WAIT_VB: begin
                // Only a fresh vblank start launches; never mid-vblank.
                if (vb_start) begin
                    cnt_d      = '0;
                    pending_d  = 1'b0;
                    clr_mode_d = clr_pend_q;
                    state_d    = clr_pend_q ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                if (bus.buf_ok) begin
                    data_d  = bus.buf_dout;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Port is free only when the CPU is not writing this cycle.
                if (bus.cpu_we == 2'b00) begin
                    pal_addr_d = cnt_q;
                    pal_dout_d = clr_mode_q ? '0 : data_q;
                    pal_we_d   = 2'b11;
                    if (cnt_q == LAST_WORD) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = clr_mode_q ? ST_WRITE : ST_READ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.cpu_we != 2'b00) begin
            pal_addr_d = bus.cpu_addr;
            pal_dout_d = bus.cpu_dout;
            pal_we_d   = bus.cpu_we;
        end

        // Requests collapse; a clear anywhere in the batch makes it a clear.
        if (bus.dma_req) begin
            pending_d  = 1'b1;
            clr_pend_d = req_clr | (pending_q & clr_pend_q);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b0;
            clr_pend_q <= 1'b0;
            clr_mode_q <= 1'b0;
            lvbl_q     <= 1'b0;
            cnt_q      <= '0;
            data_q     <= '0;
            pal_addr_q <= '0;
            pal_dout_q <= '0;
            pal_we_q   <= 2'b00;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            clr_pend_q <= clr_pend_d;
            clr_mode_q <= clr_mode_d;
            lvbl_q     <= bus.LVBL;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            pal_addr_q <= pal_addr_d;
            pal_dout_q <= pal_dout_d;
            pal_we_q   <= pal_we_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_jtcop_paldma.sv
// Randomized bench for jtcop_paldma. The reference model tracks requests,
// transfers and the expected word sequence at transaction level; every
// cycle the palette port, buffer port and status outputs are checked
// against it. Frames are 3000 cycles with a 500-cycle vblank at the start.
module tb_jtcop_paldma;
    localparam int AW     = 10;
    localparam int DW     = 16;
    localparam int NW     = 1 << AW;
    localparam int FRAME  = 3000;
    localparam int VB_LEN = 500;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtcop_paldma_if #(.AW(AW), .DW(DW)) bus ();

    jtcop_paldma #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Buffer RAM model: word n holds ~n; garbage when not valid.
    assign bus.buf_dout = bus.buf_ok ? ~{{(DW-AW){1'b0}}, bus.buf_addr} : 16'hDEAD;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_xfer = 0;

    // Reference model state.
    bit m_pending  = 1'b0;
    bit m_pend_clr = 1'b0;
    bit m_active   = 1'b0;
    bit m_clr      = 1'b0;
    bit m_quiet    = 1'b0;
    int m_idx      = 0;
    int m_t0       = 0;
    bit lvbl_prev  = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Apply current inputs on one clock edge, then check the outputs it produced.
    task automatic step();
        logic [1:0]    a_we;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_dout;
        bit a_rst, a_req, a_clr, a_fall, a_bufok;
        int lat, exp_lat;
        a_we    = bus.cpu_we;
        a_addr  = bus.cpu_addr;
        a_dout  = bus.cpu_dout;
        a_rst   = rst;
        a_req   = bus.dma_req;
        a_bufok = bus.buf_ok;
        a_fall  = lvbl_prev & ~bus.LVBL;
`ifdef JTCOP_PALDMA_CLR_EN
        a_clr   = bus.clr;
`else
        a_clr   = 1'b0;
`endif
        lvbl_prev = bus.LVBL;
        @(posedge clk);
        #1;
        cyc++;

        if (a_rst) begin
            m_pending = 1'b0;
            m_active  = 1'b0;
            m_idx     = 0;
            chk("rst_busy",     32'(bus.busy),     0);
            chk("rst_pal_we",   32'(bus.pal_we),   0);
            chk("rst_buf_cs",   32'(bus.buf_cs),   0);
            chk("rst_done",     32'(bus.done),     0);
            chk("rst_pal_addr", 32'(bus.pal_addr), 0);
            chk("rst_pal_dout", 32'(bus.pal_dout), 0);
            return;
        end

        if (a_fall) begin
            chk("busy_at_vb_start", 32'(bus.busy), 32'(m_pending));
            if (m_pending) begin
                m_pending = 1'b0;
                m_active  = 1'b1;
                m_clr     = m_pend_clr;
                m_idx     = 0;
                m_t0      = cyc;
                m_quiet   = 1'b1;
            end
        end
        if (a_req) begin
            m_pend_clr = a_clr | (m_pending & m_pend_clr);
            m_pending  = 1'b1;
        end
        if (m_active && (a_we != 2'b00 || (!a_bufok && !m_clr))) m_quiet = 1'b0;

        // Palette write port: CPU first, then the next expected DMA word.
        if (a_we != 2'b00) begin
            chk("cpu_we",   32'(bus.pal_we),   32'(a_we));
            chk("cpu_addr", 32'(bus.pal_addr), 32'(a_addr));
            chk("cpu_dout", 32'(bus.pal_dout), 32'(a_dout));
        end else if (m_active && bus.pal_we != 2'b00) begin
            chk("dma_we",   32'(bus.pal_we),   3);
            chk("dma_addr", 32'(bus.pal_addr), m_idx);
            chk("dma_dout", 32'(bus.pal_dout), m_clr ? 0 : ((~m_idx) & 32'hFFFF));
            m_idx++;
        end else begin
            chk("idle_we", 32'(bus.pal_we), 0);
        end

        chk("done", 32'(bus.done), 32'(m_active && m_idx == NW));
        if (m_active && m_idx == NW) begin
            chk("busy_after_done", 32'(bus.busy), 0);
            lat     = cyc - m_t0;
            exp_lat = m_clr ? NW : 2 * NW;
            if (m_quiet) chk("done_latency_in_range", 32'(lat >= exp_lat - 2 && lat <= exp_lat + 2), 1);
            n_xfer++;
            $display("xfer %0d: %s of %0d words done, %0d cycles after vblank start%s",
                     n_xfer, m_clr ? "clear" : "copy", NW, lat, m_quiet ? "" : " (contended)");
            m_active = 1'b0;
        end

        if (!m_active || m_clr) chk("buf_cs_off", 32'(bus.buf_cs), 0);
        else if (bus.buf_cs)     chk("buf_addr", 32'(bus.buf_addr), m_idx);
    endtask

    task automatic run_frame(input int req_a, input int req_b, input bit req_clr,
                             input bit cpu_rand, input bit buf_rand,
                             input bit do_cont, input bit do_stall, input bit do_rst);
        int cont_left  = 0;
        bit cont_done  = 1'b0;
        int stall_left = 0;
        bit stall_done = 1'b0;
        bit rst_done   = 1'b0;
        bit stalled;
        for (int c = 0; c < FRAME; c++) begin
            bus.LVBL    = (c >= VB_LEN);
            bus.dma_req = (c == req_a || c == req_b);
`ifdef JTCOP_PALDMA_CLR_EN
            bus.clr     = bus.dma_req & req_clr;
`endif
            rst         = 1'b0;
            bus.cpu_we  = 2'b00;
            bus.buf_ok  = 1'b1;
            stalled     = 1'b0;
            if (cpu_rand && $urandom_range(0, 15) == 0) begin
                bus.cpu_we   = 2'($urandom_range(1, 3));
                bus.cpu_addr = AW'($urandom());
                bus.cpu_dout = DW'($urandom());
            end
            if (do_cont && m_active && m_idx == 200 && !cont_done) begin
                cont_done = 1'b1;
                cont_left = 3;
            end
            if (cont_left > 0) begin
                cont_left--;
                bus.cpu_we   = 2'b01;
                bus.cpu_addr = AW'(5);
                bus.cpu_dout = 16'h0ABC;
            end
            if (buf_rand) bus.buf_ok = ($urandom_range(0, 3) != 0);
            if (do_stall && m_active && m_idx == 3 && !stall_done) begin
                stall_done = 1'b1;
                stall_left = 7;
            end
            if (stall_left > 0) begin
                stall_left--;
                bus.buf_ok = 1'b0;
                stalled    = 1'b1;
            end
            if (do_rst && m_active && m_idx == 500 && !rst_done) begin
                rst_done    = 1'b1;
                rst         = 1'b1;
                bus.cpu_we  = 2'b00;
                bus.dma_req = 1'b0;
            end
            step();
            if (stalled) begin
                chk("stall_buf_cs",   32'(bus.buf_cs),   1);
                chk("stall_buf_addr", 32'(bus.buf_addr), 3);
                chk("stall_no_write", 32'(bus.pal_we),   0);
            end
        end
    endtask

    initial begin
        bus.LVBL     = 1'b1;
        bus.dma_req  = 1'b0;
`ifdef JTCOP_PALDMA_CLR_EN
        bus.clr      = 1'b0;
`endif
        bus.cpu_addr = '0;
        bus.cpu_dout = '0;
        bus.cpu_we   = 2'b00;
        bus.buf_ok   = 1'b1;
        rst          = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (20) step();

        // f0: request in active video; f1: quiet copy with latency check.
        run_frame(int'($urandom_range(1000, 1500)), -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(-1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // f2: request inside vblank must wait for f3's vblank start.
        run_frame(int'($urandom_range(100, 300)), -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // f3: copy with CPU contention and a buffer stall; two requests while busy.
        run_frame(1200, 1500, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        // f4: the single extra transfer, random CPU writes and buffer latency.
        run_frame(-1, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // f5: nothing pending, so no DMA writes; new request for f6.
        run_frame(int'($urandom_range(800, 2000)), -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // f6: reset at word 500; f7 must stay idle.
        run_frame(-1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef JTCOP_PALDMA_CLR_EN
        run_frame(1000, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        run_frame(-1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        // f8: clear transfer when the feature is built in, otherwise idle.
        run_frame(-1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        chk("end_busy", 32'(bus.busy), 32'(m_active | m_pending));
`ifdef JTCOP_PALDMA_CLR_EN
        chk("transfer_count", n_xfer, 4);
`else
        chk("transfer_count", n_xfer, 3);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
